elevator_ctrl: RTL
==================

# elevator_ctrl

Scheduler/sequencer for the elevator car. Latches floor-button requests, serves them in SCAN order (keeps its direction while requests remain ahead), and times floor-to-floor travel and door dwell. Drives the `floor`, `countdown`, `status` and `floor_btn` inputs of the `Display` block, and exposes the pending-request vector.

## Interface
- `NFLOOR`, 8: number of floors, 2..16. Floors are numbered 0..NFLOOR-1.
- `TICK_DIV`, 100_000_000: `ck` cycles per countdown step. The bench overrides it to 2.
- `MOVE_TICKS`, 3: countdown steps per one-floor move, 1..15.
- `DOOR_TICKS`, 5: countdown steps of door dwell, 1..15.

Ports:
- `ck` in 1: system clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `btn` in NFLOOR: floor-request buttons. Any bit high in a cycle sets that request.
- `floor` out 4: current floor.
- `countdown` out 4: countdown steps remaining in the current MOVE/DOOR phase; 0 in IDLE.
- `status` out 4: one-hot state. IDLE=0001, UP=0010, DOWN=0100, DOOR=1000.
- `pending` out NFLOOR: latched requests, wired to Display `floor_btn`.

## Operation
- **Reset values** (on the edge where `rst`=1): `floor`=0, `countdown`=0, `status`=IDLE, `pending`=0, `last_dir`=UP, prescaler=0. Reset wins over every other event, including mid-move and mid-door.
- **Request latch:** `pending[i]` is set on the edge after `btn[i]`=1.
  - A bit is cleared only when floor i is served.
  - If set and clear occur in the same cycle, clear wins.
- **Prescaler:** counts 0..TICK_DIV-1 and is forced to 0 on every state entry. `tick`=1 when the count equals TICK_DIV-1.
- **States:**
  - IDLE, evaluated each cycle:
    - `pending[floor]` → DOOR, and clear that bit.
    - Otherwise, requests both above and below → move in `last_dir`.
    - Otherwise, requests only above → UP; only below → DOWN.
    - Otherwise, stay in IDLE.
  - UP/DOWN:
    - On entry: `countdown`=MOVE_TICKS, `last_dir` updated.
    - On `tick`: `countdown`−1.
    - On `tick` with `countdown`=1, the arrival edge: `floor`±1. Then:
      - Request at the new floor → DOOR, and clear that bit (a `btn` for that floor in the same cycle is also absorbed).
      - Otherwise, request further ahead → reload MOVE_TICKS and stay in the same direction.
      - Otherwise → IDLE.
  - DOOR:
    - On entry: `countdown`=DOOR_TICKS.
    - On `tick`: `countdown`−1.
    - A `btn` for the current floor reloads DOOR_TICKS, resets the prescaler and does not set `pending`.
    - On `tick` with `countdown`=1 → IDLE, with `countdown`=0.
- **Range rules:** `floor` never leaves 0..NFLOOR-1. UP is never entered at the top floor, and DOWN never at floor 0. Width: `countdown` is 4 bits, so parameters are ≤15.

## Timing
- `btn` → `pending` visible: 1 cycle.
- `pending` visible → `status` leaves IDLE: 1 cycle.
- Each floor step lasts exactly MOVE_TICKS×TICK_DIV cycles from state entry or reload. DOOR lasts exactly DOOR_TICKS×TICK_DIV cycles unless reloaded.
- DOOR → IDLE → next move: 1 IDLE cycle minimum.
- All outputs are registered. There is no combinational path from `btn` to any output.

## Structure
- `elevator_pkg`: state encoding and status one-hot constants, `DIR_UP`/`DIR_DOWN`, and the helper functions `any_above(pending, floor)` and `any_below(pending, floor)`.
- Sub-module `tick_prescaler` (parameter TICK_DIV; ports `ck`, `rst`, `clr`, `tick`).
- The top level is a single FSM with the request register and countdown register.

## Test plan
All scenarios use TICK_DIV=2, MOVE_TICKS=3, DOOR_TICKS=2.
1. Assert `rst` for 2 cycles → `floor`=0, `countdown`=0, `status`=0001, `pending`=0.
2. At floor 0, pulse `btn[3]` for 1 cycle:
   - `pending`=0x08 the next cycle; `status`=0010 one cycle later.
   - `floor`=1, 2, 3 at 6-cycle intervals, then `status`=1000, `pending`=0, `countdown`=2.
   - IDLE 4 cycles later.
3. At floor 2 moving UP toward 6, press `btn[1]` and `btn[5]`:
   - Stops at 5 (DOOR), then 6 (DOOR), then DOWN to 1.
   - `pending` ends at 0.
4. In IDLE at floor 4, pulse `btn[4]` → `status`=1000 after 1 cycle, `floor` stays 4, `pending[4]` never observed high.
5. During DOOR at floor 4 with `countdown`=1, pulse `btn[4]` → `countdown` reloads to 2 and DOOR is extended by 4 cycles.
6. Assert `rst` mid-move (floor 2, `countdown`=2, UP) → the next cycle matches scenario 1 and the earlier requests are lost.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, status one-hot codes, direction
// constants and request-search helpers for the elevator controller.
package elevator_pkg;

    // Request vectors are zero-extended to this width before searching.
    localparam int unsigned MAX_FLOOR = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DOOR = 2'd3
    } state_t;

    localparam logic [3:0] STATUS_IDLE = 4'b0001;
    localparam logic [3:0] STATUS_UP   = 4'b0010;
    localparam logic [3:0] STATUS_DOWN = 4'b0100;
    localparam logic [3:0] STATUS_DOOR = 4'b1000;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // True when any request is latched strictly above floor fl.
    function automatic logic any_above(input logic [MAX_FLOOR-1:0] req,
                                       input logic [3:0]           fl);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(MAX_FLOOR); i++) begin
            if ((4'(i) > fl) && req[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when any request is latched strictly below floor fl.
    function automatic logic any_below(input logic [MAX_FLOOR-1:0] req,
                                       input logic [3:0]           fl);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(MAX_FLOOR); i++) begin
            if ((4'(i) < fl) && req[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/elevator_ctrl_tick_prescaler.sv
// tick_prescaler: divides ck down to one-cycle countdown ticks.
// Ports: ck clock, rst sync active-high reset, clr restarts the count at 0,
//        tick high while the count sits at TICK_DIV-1.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic ck,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running modulo-TICK_DIV counter, restartable by clr.
    always_ff @(posedge ck) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: latches floor requests and serves them in SCAN order,
// timing one-floor moves and door dwell in prescaled countdown steps.
// Ports: ck clock, rst sync active-high reset, btn floor-request buttons,
//        floor current floor, countdown steps left in MOVE/DOOR (0 in IDLE),
//        status one-hot IDLE/UP/DOWN/DOOR, pending latched requests.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NFLOOR     = 8,
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned MOVE_TICKS = 3,
    parameter int unsigned DOOR_TICKS = 5
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [NFLOOR-1:0] btn,
    output logic [3:0]        floor,
    output logic [3:0]        countdown,
    output logic [3:0]        status,
    output logic [NFLOOR-1:0] pending
);

    localparam logic [3:0] MOVE_LOAD = 4'(MOVE_TICKS);
    localparam logic [3:0] DOOR_LOAD = 4'(DOOR_TICKS);

    state_t               state;
    logic                 last_dir;
    logic                 tick;
    logic                 presc_clr_c;
    logic [MAX_FLOOR-1:0] req_c;
    logic [MAX_FLOOR-1:0] btn_c;
    logic [MAX_FLOOR-1:0] clr_mask_c;
    logic [3:0]           next_floor_c;
    logic                 up_req_c;
    logic                 dn_req_c;
    logic                 ahead_c;
    logic                 stop_c;
    logic                 at_floor_c;
    logic                 arrive_c;

    // The prescaler is held at 0 through IDLE so every move/door entry from
    // IDLE starts a full step; other entries coincide with a tick wrap.
    assign presc_clr_c = (state == ST_IDLE) || ((state == ST_DOOR) && btn_c[floor]);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .ck   (ck),
        .rst  (rst),
        .clr  (presc_clr_c),
        .tick (tick)
    );

    assign req_c        = MAX_FLOOR'(pending);
    assign btn_c        = MAX_FLOOR'(btn);
    assign next_floor_c = (state == ST_DOWN) ? floor - 4'd1 : floor + 4'd1;
    assign up_req_c     = any_above(req_c, floor);
    assign dn_req_c     = any_below(req_c, floor);
    assign ahead_c      = (state == ST_DOWN) ? any_below(req_c, next_floor_c)
                                             : any_above(req_c, next_floor_c);
    assign stop_c       = req_c[next_floor_c];
    assign at_floor_c   = req_c[floor] | btn_c[floor];
    assign arrive_c     = ((state == ST_UP) || (state == ST_DOWN)) && tick
                          && (countdown == 4'd1);

    // Requests served this cycle; clearing beats a same-cycle button press.
    always_comb begin
        clr_mask_c = '0;
        case (state)
            ST_IDLE:        if (at_floor_c) clr_mask_c[floor] = 1'b1;
            ST_UP, ST_DOWN: if (arrive_c && stop_c) clr_mask_c[next_floor_c] = 1'b1;
            ST_DOOR:        clr_mask_c[floor] = 1'b1;
            default:        ;
        endcase
    end

    // Scheduler FSM with request and countdown registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= ST_IDLE;
            status    <= STATUS_IDLE;
            floor     <= 4'd0;
            countdown <= 4'd0;
            pending   <= '0;
            last_dir  <= DIR_UP;
        end else begin
            pending <= (pending | btn) & ~clr_mask_c[NFLOOR-1:0];
            case (state)
                ST_IDLE: begin
                    if (at_floor_c) begin
                        state     <= ST_DOOR;
                        status    <= STATUS_DOOR;
                        countdown <= DOOR_LOAD;
                    end else if (up_req_c && (!dn_req_c || (last_dir == DIR_UP))) begin
                        state     <= ST_UP;
                        status    <= STATUS_UP;
                        countdown <= MOVE_LOAD;
                        last_dir  <= DIR_UP;
                    end else if (dn_req_c) begin
                        state     <= ST_DOWN;
                        status    <= STATUS_DOWN;
                        countdown <= MOVE_LOAD;
                        last_dir  <= DIR_DOWN;
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (tick) begin
                        if (countdown == 4'd1) begin
                            floor <= next_floor_c;
                            if (stop_c) begin
                                state     <= ST_DOOR;
                                status    <= STATUS_DOOR;
                                countdown <= DOOR_LOAD;
                            end else if (ahead_c) begin
                                countdown <= MOVE_LOAD;
                            end else begin
                                state     <= ST_IDLE;
                                status    <= STATUS_IDLE;
                                countdown <= 4'd0;
                            end
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end
                end
                ST_DOOR: begin
                    // A press at the open floor keeps the door open.
                    if (btn_c[floor]) begin
                        countdown <= DOOR_LOAD;
                    end else if (tick) begin
                        if (countdown == 4'd1) begin
                            state     <= ST_IDLE;
                            status    <= STATUS_IDLE;
                            countdown <= 4'd0;
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    status    <= STATUS_IDLE;
                    countdown <= 4'd0;
                end
            endcase
        end
    end

endmodule
